// File: rtl/obi_pkg.sv
// Shared OBI types for the memory responder: request/response structs,
// the wait-state FSM encoding, the latency ceiling and a byte-lane merge helper.
package obi_pkg;

   localparam int OBI_MEM_MAX_LATENCY = 4;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

   typedef enum logic [0:0] {
      OBI_MEM_IDLE = 1'b0,
      OBI_MEM_WAIT = 1'b1
   } obi_mem_wait_state_e;

   // Merge wdata into old on the byte lanes selected by be.
   function automatic logic [31:0] apply_be(input logic [31:0] old,
                                            input logic [31:0] wdata,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/obi_mem_resp_pipe.sv
// Fixed-latency {valid, data} delay line for the responder's response path.
// Each data stage loads only when the stage before it holds a valid entry,
// so the output data keeps its last returned value while out_valid is low.
module obi_mem_resp_pipe #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [DEPTH-1:0] valid_q;
   logic [WIDTH-1:0] data_q [DEPTH];

   // Shift valids every cycle; advance data only behind a valid entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '{default: '0};
      end else begin
         valid_q[0] <= in_valid;
         if (in_valid) data_q[0] <= in_data;
         for (int k = 1; k < DEPTH; k++) begin
            valid_q[k] <= valid_q[k-1];
            if (valid_q[k-1]) data_q[k] <= data_q[k-1];
         end
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/obi_mem_responder.sv
// Single-port OBI responder over a word-addressed 32-bit memory.
// One transaction per req&&gnt handshake, one rvalid per handshake after
// RESP_LATENCY edges, responses in order, no back-pressure on rvalid.
// Optional grant wait states are compiled in with the macro OBI_MEM_WAIT_EN;
// without it gnt follows req directly and WAIT_CYCLES has no effect.
//
// Handshake: a request is accepted on any cycle where req and gnt are both
// high; gnt never depends on addr/we/be/wdata, and a master that drops req
// before gnt simply abandons the request (no response is produced).
module obi_mem_responder
   import obi_pkg::*;
#(
   parameter int NUM_WORDS    = 1024,
   parameter int RESP_LATENCY = 1,
   parameter int WAIT_CYCLES  = 0
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  obi_req_t  req_i,
   output obi_resp_t resp_o
);

   localparam int IDX_W = $clog2(NUM_WORDS);

   logic              gnt;
   logic              hs;
   logic [IDX_W-1:0]  idx;
   logic [31:0]       rd_word;
   logic              pipe_valid;
   logic [31:0]       pipe_data;
   logic [31:0]       mem [NUM_WORDS];
   logic              unused_addr_bits;

   // Upper address bits and the byte offset alias away.
   assign idx              = req_i.addr[IDX_W+1:2];
   assign unused_addr_bits = ^{req_i.addr[31:IDX_W+2], req_i.addr[1:0]};

`ifdef OBI_MEM_WAIT_EN
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   obi_mem_wait_state_e state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                wait_gnt;

   // State and wait counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= OBI_MEM_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: count down the wait states, abandon on req drop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         OBI_MEM_IDLE: begin
            if (req_i.req && (WAIT_CYCLES > 0)) begin
               state_d = OBI_MEM_WAIT;
               cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            end
         end
         OBI_MEM_WAIT: begin
            if (!req_i.req) begin
               state_d = OBI_MEM_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = OBI_MEM_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = OBI_MEM_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Grant: immediately in IDLE with no wait states, else at count zero.
   always_comb begin
      wait_gnt = 1'b0;
      case (state_q)
         OBI_MEM_IDLE: wait_gnt = req_i.req && (WAIT_CYCLES == 0);
         OBI_MEM_WAIT: wait_gnt = req_i.req && (cnt_q == '0);
         default:      wait_gnt = 1'b0;
      endcase
   end

   assign gnt = wait_gnt & rst_ni;
`else
   localparam int unused_wait_cycles = WAIT_CYCLES;

   assign gnt = req_i.req & rst_ni;
`endif

   assign hs = req_i.req & gnt;

   // Byte-lane write on the handshake edge; memory is deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (hs && req_i.we) mem[idx] <= apply_be(mem[idx], req_i.wdata, req_i.be);
   end

   // Read data is sampled on the handshake edge; writes answer with zero.
   always_comb begin
      rd_word = req_i.we ? 32'h0 : mem[idx];
   end

   obi_mem_resp_pipe #(
      .DEPTH (RESP_LATENCY),
      .WIDTH (32)
   ) u_pipe (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .in_valid  (hs),
      .in_data   (rd_word),
      .out_valid (pipe_valid),
      .out_data  (pipe_data)
   );

   // Pack the response struct.
   always_comb begin
      resp_o.gnt    = gnt;
      resp_o.rvalid = pipe_valid;
      resp_o.rdata  = pipe_data;
   end

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench for obi_mem_responder: four instances cover latency 1, 3, 2
// and a WAIT_CYCLES=2 build (wait states only honoured with OBI_MEM_WAIT_EN).
module tb_obi_mem_responder;
   import obi_pkg::*;

   logic      clk;
   logic      rst_n;
   obi_req_t  req_a, req_b, req_c, req_d;
   obi_resp_t resp_a, resp_b, resp_c, resp_d;
   int        n_tests;
   int        n_fail;

   obi_mem_responder #(.NUM_WORDS(1024), .RESP_LATENCY(1), .WAIT_CYCLES(0)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .resp_o(resp_a));
   obi_mem_responder #(.NUM_WORDS(1024), .RESP_LATENCY(3), .WAIT_CYCLES(0)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .resp_o(resp_b));
   obi_mem_responder #(.NUM_WORDS(1024), .RESP_LATENCY(2), .WAIT_CYCLES(0)) u_c (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req_c), .resp_o(resp_c));
   obi_mem_responder #(.NUM_WORDS(1024), .RESP_LATENCY(1), .WAIT_CYCLES(2)) u_d (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req_d), .resp_o(resp_d));

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obi_req_t mk(input logic we, input logic [3:0] be,
                                   input logic [31:0] addr, input logic [31:0] wdata);
      obi_req_t r;
      r.req   = 1'b1;
      r.we    = we;
      r.be    = be;
      r.addr  = addr;
      r.wdata = wdata;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change just after the rising edge; outputs are checked at the falling edge.
   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      req_a = '0; req_b = '0; req_c = '0; req_d = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_gnt", {31'b0, resp_a.gnt}, 32'h0);
      chk("reset_rvalid", {31'b0, resp_a.rvalid}, 32'h0);
      chk("reset_rdata", resp_a.rdata, 32'h0);
      chk("reset_rvalid_b", {31'b0, resp_b.rvalid}, 32'h0);
      next_cycle();
      rst_n = 1'b1;

      // Full write then read at 0x10, latency 1.
      next_cycle();
      req_a = mk(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
      @(negedge clk);
      chk("wr_gnt", {31'b0, resp_a.gnt}, 32'h1);
      chk("wr_no_early_rvalid", {31'b0, resp_a.rvalid}, 32'h0);
      next_cycle();
      req_a = mk(1'b0, 4'h0, 32'h10, 32'h0);
      @(negedge clk);
      chk("rd_gnt", {31'b0, resp_a.gnt}, 32'h1);
      chk("wr_rvalid", {31'b0, resp_a.rvalid}, 32'h1);
      chk("wr_rdata_zero", resp_a.rdata, 32'h0);
      next_cycle();
      req_a = '0;
      @(negedge clk);
      chk("idle_gnt", {31'b0, resp_a.gnt}, 32'h0);
      chk("rd_rvalid", {31'b0, resp_a.rvalid}, 32'h1);
      chk("rd_data", resp_a.rdata, 32'hDEADBEEF);
      next_cycle();
      @(negedge clk);
      chk("rvalid_one_cycle", {31'b0, resp_a.rvalid}, 32'h0);
      chk("rdata_hold", resp_a.rdata, 32'hDEADBEEF);

      // Partial write over 0x11223344 at 0x20, then read back.
      next_cycle();
      req_a = mk(1'b1, 4'hF, 32'h20, 32'h11223344);
      next_cycle();
      req_a = mk(1'b1, 4'b0010, 32'h20, 32'h0000AA00);
      next_cycle();
      req_a = mk(1'b0, 4'hF, 32'h20, 32'h0);
      next_cycle();
      req_a = '0;
      @(negedge clk);
      chk("partial_rvalid", {31'b0, resp_a.rvalid}, 32'h1);
      chk("partial_rdata", resp_a.rdata, 32'h1122AA44);

      // Aliasing: 0x1000 wraps onto word 0; byte offset ignored.
      next_cycle();
      req_a = mk(1'b1, 4'hF, 32'h1000, 32'h5A5A5A5A);
      next_cycle();
      req_a = mk(1'b0, 4'h0, 32'h0, 32'h0);
      next_cycle();
      req_a = mk(1'b0, 4'h0, 32'h3, 32'h0);
      @(negedge clk);
      chk("alias_rdata", resp_a.rdata, 32'h5A5A5A5A);
      next_cycle();
      req_a = '0;
      @(negedge clk);
      chk("offset_rvalid", {31'b0, resp_a.rvalid}, 32'h1);
      chk("offset_rdata", resp_a.rdata, 32'h5A5A5A5A);

      // Latency 3: preload words 0..7 with their index, drain, then burst read.
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         req_b = mk(1'b1, 4'hF, 32'(i * 4), 32'(i));
      end
      next_cycle();
      req_b = '0;
      repeat (4) next_cycle();
      for (int k = 0; k < 12; k++) begin
         next_cycle();
         req_b = (k < 8) ? mk(1'b0, 4'h0, 32'(k * 4), 32'h0) : '0;
         @(negedge clk);
         chk($sformatf("burst_gnt_%0d", k), {31'b0, resp_b.gnt}, (k < 8) ? 32'h1 : 32'h0);
         chk($sformatf("burst_rvalid_%0d", k), {31'b0, resp_b.rvalid},
             (k >= 3 && k < 11) ? 32'h1 : 32'h0);
         if (k >= 3 && k < 11) chk($sformatf("burst_rdata_%0d", k), resp_b.rdata, 32'(k - 3));
      end

      // Latency 2: reset lands between a read grant and its rvalid.
      next_cycle();
      req_c = mk(1'b1, 4'hF, 32'h14, 32'h12345678);
      next_cycle();
      req_c = '0;
      repeat (3) next_cycle();
      req_c = mk(1'b0, 4'h0, 32'h14, 32'h0);
      @(negedge clk);
      chk("rst_case_gnt", {31'b0, resp_c.gnt}, 32'h1);
      next_cycle();
      rst_n = 1'b0;
      @(negedge clk);
      chk("in_reset_gnt", {31'b0, resp_c.gnt}, 32'h0);
      chk("in_reset_rvalid", {31'b0, resp_c.rvalid}, 32'h0);
      chk("in_reset_rdata_a", resp_a.rdata, 32'h0);
      chk("in_reset_rdata_b", resp_b.rdata, 32'h0);
      next_cycle();
      req_c = '0;
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("post_reset_rvalid_%0d", k), {31'b0, resp_c.rvalid}, 32'h0);
         next_cycle();
      end
      // Memory survives reset.
      req_c = mk(1'b0, 4'h0, 32'h14, 32'h0);
      next_cycle();
      req_c = '0;
      @(negedge clk);
      chk("post_reset_not_yet", {31'b0, resp_c.rvalid}, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("post_reset_rvalid", {31'b0, resp_c.rvalid}, 32'h1);
      chk("post_reset_rdata", resp_c.rdata, 32'h12345678);

`ifdef OBI_MEM_WAIT_EN
      // Two wait states with req held: gnt on the third req cycle.
      next_cycle();
      req_d = mk(1'b1, 4'hF, 32'h8, 32'hCAFEF00D);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("wait_gnt_%0d", k), {31'b0, resp_d.gnt}, (k == 2) ? 32'h1 : 32'h0);
         chk($sformatf("wait_rvalid_%0d", k), {31'b0, resp_d.rvalid}, 32'h0);
         next_cycle();
      end
      req_d = '0;
      @(negedge clk);
      chk("wait_resp", {31'b0, resp_d.rvalid}, 32'h1);
      // One req cycle then drop inside WAIT: no grant, no response.
      next_cycle();
      req_d = mk(1'b1, 4'hF, 32'hC, 32'h1);
      @(negedge clk);
      chk("abort_gnt", {31'b0, resp_d.gnt}, 32'h0);
      next_cycle();
      req_d = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("abort_rvalid_%0d", k), {31'b0, resp_d.rvalid}, 32'h0);
         next_cycle();
      end
      // Fresh request waits two cycles again.
      req_d = mk(1'b1, 4'hF, 32'hC, 32'h2);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("rewait_gnt_%0d", k), {31'b0, resp_d.gnt}, (k == 2) ? 32'h1 : 32'h0);
         next_cycle();
      end
      req_d = '0;
      @(negedge clk);
      chk("rewait_resp", {31'b0, resp_d.rvalid}, 32'h1);
`else
      // Without wait-state support gnt follows req in the same cycle.
      next_cycle();
      req_d = mk(1'b1, 4'hF, 32'h8, 32'hCAFEF00D);
      @(negedge clk);
      chk("nowait_gnt", {31'b0, resp_d.gnt}, 32'h1);
      next_cycle();
      req_d = '0;
      @(negedge clk);
      chk("nowait_gnt_drop", {31'b0, resp_d.gnt}, 32'h0);
      chk("nowait_rvalid", {31'b0, resp_d.rvalid}, 32'h1);
      chk("nowait_rdata", resp_d.rdata, 32'h0);
`endif

      next_cycle();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
